span_writer: RTL and testbench

- Framebuffer write stage between the rasterizer and the 640x480 RGB332 frame memory.
- Accepts horizontal span commands (y, x0, x1, color) over a valid/ready handshake and buffers them in a small FIFO.
- Expands each span into one pixel write per clock on the addr/wen/dout port; spans are clipped to the screen.
- Pulses done once all queued work has drained after a flush request.

---
 rtl/span_writer_if.sv | 22 ++
 rtl/span_writer.sv | 146 ++++++++++++++
 tb/tb_span_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/span_writer_if.sv
// Span command handshake between the rasterizer (master) and the framebuffer
// write stage (slave).
interface span_writer_if #(
    parameter int COLOR_W = 8
);
    logic               span_valid;
    logic               span_ready;
    logic [9:0]         span_y;
    logic [9:0]         span_x0;
    logic [9:0]         span_x1;
    logic [COLOR_W-1:0] span_color;

    modport master (
        output span_valid, span_y, span_x0, span_x1, span_color,
        input  span_ready
    );

    modport slave (
        input  span_valid, span_y, span_x0, span_x1, span_color,
        output span_ready
    );
endinterface

// File: rtl/span_writer.sv
// Framebuffer write stage: queues horizontal span commands and expands each
// into one clipped pixel write per clock.
//
// state | meaning
// IDLE  | nothing to draw, waiting for a queued span
// SETUP | pop head span, clip it, load walker (wen low)
// DRAW  | one pixel write per cycle until cur_x reaches xe
module span_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    span_writer_if.slave       span,
    input  logic               flush,
    output logic [ADDR_W-1:0]  addr,
    output logic               wen,
    output logic [COLOR_W-1:0] dout,
    output logic               busy,
    output logic               done
);
    localparam int         PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [9:0] H_LIM  = 10'(H_RES);
    localparam logic [9:0] H_LAST = 10'(H_RES - 1);
    localparam logic [9:0] V_LIM  = 10'(V_RES);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    typedef struct packed {
        logic [9:0]         y;
        logic [9:0]         x0;
        logic [9:0]         x1;
        logic [COLOR_W-1:0] color;
    } span_t;

    span_t              mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    logic               more_after_pop;

    state_t             state;
    logic [9:0]         cur_x;
    logic [9:0]         xe;
    logic               flush_pending;
    logic               done_cond;

    span_t              head;
    logic               head_keep;
    logic [9:0]         head_xe;
    logic [ADDR_W-1:0]  head_base;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = span.span_valid && !full;
    assign span.span_ready = !full;

    assign more_after_pop = (count > (PTR_W+1)'(1)) || push;

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign head_keep = (head.y < V_LIM) && (head.x0 < H_LIM) && (head.x0 <= head.x1);
    assign head_xe   = (head.x1 > H_LAST) ? H_LAST : head.x1;
    assign head_base = ADDR_W'(head.y) * ADDR_W'(H_RES);

    assign done_cond = flush_pending && empty && (state == IDLE) && !push;
    assign busy      = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{y: span.span_y, x0: span.span_x0,
                                        x1: span.span_x1, color: span.span_color};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            flush_pending <= 1'b0;
            done          <= 1'b0;
            addr          <= '0;
            wen           <= 1'b0;
            dout          <= '0;
            cur_x         <= '0;
            xe            <= '0;
        end else begin
            done <= done_cond;
            // A flush landing on the done cycle is already covered by that done.
            if (done_cond) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    rd_ptr <= rd_ptr + (PTR_W+1)'(1);
                    if (head_keep) begin
                        state <= DRAW;
                        wen   <= 1'b1;
                        addr  <= head_base + ADDR_W'(head.x0);
                        dout  <= head.color;
                        cur_x <= head.x0;
                        xe    <= head_xe;
                    end else if (more_after_pop) begin
                        state <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAW: begin
                    if (cur_x == xe) begin
                        wen   <= 1'b0;
                        state <= (!empty || push) ? SETUP : IDLE;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        cur_x <= cur_x + 10'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wen   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_span_writer.sv
// Scoreboard bench for span_writer: stimulus queues expected pixel writes and
// done pulses, a negedge monitor pops and compares them in order.
module tb_span_writer;
    logic        clk_tb = 1'b0;
    logic        rst_tb = 1'b0;
    logic        flush  = 1'b0;
    logic [18:0] addr;
    logic        wen;
    logic [7:0]  dout;
    logic        busy;
    logic        done;

    span_writer_if #(.COLOR_W(8)) sif ();

    span_writer #(
        .H_RES(640), .V_RES(480), .FIFO_DEPTH(4), .ADDR_W(19), .COLOR_W(8)
    ) dut (
        .clk   (clk_tb),
        .reset (rst_tb),
        .span  (sif),
        .flush (flush),
        .addr  (addr),
        .wen   (wen),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk_tb = ~clk_tb;

    typedef struct {
        bit is_done;
        int addr;
        int color;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   full_cycles = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic exp_write(input int a, input int c);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.color   = c;
        sbq.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = 0;
        e.color   = 0;
        sbq.push_back(e);
    endtask

    // Monitor: every wen/done cycle must match the head of the scoreboard.
    always @(negedge clk_tb) begin
        if (rst_tb) begin
            if (!sif.span_ready) full_cycles++;
            if (wen) begin
                check("write_expected", int'(sbq.size() > 0), 1);
                check("addr_in_screen", int'(addr < 19'd307200), 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    check("write_kind", int'(mon_e.is_done), 0);
                    check("write_addr", int'(addr), mon_e.addr);
                    check("write_dout", int'(dout), mon_e.color);
                end
            end
            if (done) begin
                check("done_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    check("done_order", int'(mon_e.is_done), 1);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_span(input int y, input int x0, input int x1, input int c);
        int ok;
        sif.span_y     = 10'(y);
        sif.span_x0    = 10'(x0);
        sif.span_x1    = 10'(x1);
        sif.span_color = 8'(c);
        sif.span_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_tb);
            if (sif.span_ready) begin
                ok = 1;
                break;
            end
        end
        check("span_accept", ok, 1);
        @(posedge clk_tb);
        #1;
    endtask

    task automatic drop_valid();
        sif.span_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk_tb);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_tb);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_done_seen"}, seen, 1);
        @(negedge clk_tb);
        check({nm, "_busy_low"}, int'(busy), 0);
        check({nm, "_sb_empty"}, sbq.size(), 0);
        @(posedge clk_tb);
        #1;
    endtask

    int b2b_addr[12] = '{650, 651, 1290, 1291, 1930, 1931,
                         2570, 2571, 3210, 3211, 3850, 3851};
    int full_before;

    initial begin
        sif.span_valid = 1'b0;
        sif.span_y     = '0;
        sif.span_x0    = '0;
        sif.span_x1    = '0;
        sif.span_color = '0;
        repeat (3) @(posedge clk_tb);
        #1 rst_tb = 1'b1;

        // Reset state
        @(negedge clk_tb);
        check("rst_addr", int'(addr), 0);
        check("rst_wen", int'(wen), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(sif.span_ready), 1);
        @(posedge clk_tb);
        #1;

        // Single span with latency check, then flush
        for (int i = 0; i < 4; i++) exp_write(i, 8'hE0);
        exp_done();
        send_span(0, 0, 3, 8'hE0);
        drop_valid();
        @(negedge clk_tb);
        check("lat_idle_wen", int'(wen), 0);
        @(negedge clk_tb);
        check("lat_setup_wen", int'(wen), 0);
        @(negedge clk_tb);
        check("lat_first_wen", int'(wen), 1);
        @(posedge clk_tb);
        #1;
        pulse_flush();
        wait_done("single");

        // Clipped span at the last row
        for (int i = 0; i < 10; i++) exp_write(307190 + i, 8'h1C);
        exp_done();
        send_span(479, 630, 700, 8'h1C);
        drop_valid();
        pulse_flush();
        wait_done("clip");

        // Rejected spans produce no writes, only done
        exp_done();
        send_span(480, 0, 5, 8'h11);
        send_span(0, 640, 700, 8'h22);
        send_span(3, 5, 4, 8'h33);
        drop_valid();
        pulse_flush();
        wait_done("reject");

        // Back-to-back spans fill the FIFO; a second flush while pending adds no done
        for (int i = 0; i < 12; i++) exp_write(b2b_addr[i], 8'h10 + (i / 2) + 1);
        exp_done();
        full_before = full_cycles;
        for (int y = 1; y <= 6; y++) send_span(y, 10, 11, 8'h10 + y);
        drop_valid();
        check("b2b_ready_dropped", int'(full_cycles > full_before), 1);
        pulse_flush();
        pulse_flush();
        wait_done("b2b");
        repeat (10) @(posedge clk_tb);
        #1;

        // Reset during the third pixel of a long span
        exp_write(1280, 8'h55);
        exp_write(1281, 8'h55);
        exp_write(1282, 8'h55);
        send_span(2, 0, 99, 8'h55);
        drop_valid();
        repeat (4) @(posedge clk_tb);
        @(negedge clk_tb);
        #1 rst_tb = 1'b0;
        #1;
        check("rst_mid_wen", int'(wen), 0);
        repeat (2) @(posedge clk_tb);
        #1 rst_tb = 1'b1;
        @(negedge clk_tb);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ready", int'(sif.span_ready), 1);
        check("post_rst_done", int'(done), 0);
        repeat (20) @(posedge clk_tb);
        #1;
        check("post_rst_sb_empty", sbq.size(), 0);
        exp_done();
        pulse_flush();
        wait_done("after_reset");

        // Flush and push in the same idle cycle: write must precede done
        exp_write(7, 8'hA5);
        exp_done();
        flush = 1'b1;
        send_span(0, 7, 7, 8'hA5);
        flush = 1'b0;
        drop_valid();
        wait_done("flush_push");

        repeat (10) @(posedge clk_tb);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
